// File: rtl/l1_mem_arbiter.sv
// Shared 128-bit memory port arbiter: serializes I-cache refills and D-cache
// refills/write-backs, one outstanding transaction, response steered to owner.
package cache_pkg;

  typedef struct packed {
    logic [31:0] addr;
  } mem_r_req_bus_t;

  typedef struct packed {
    logic [127:0] rdata;
    logic [1:0]   rresp;
  } mem_r_resp_bus_t;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [15:0]  wmask;
  } mem_w_req_bus_t;

  typedef struct packed {
    logic [1:0] bresp;
  } mem_w_resp_bus_t;

endpackage

module l1_mem_arbiter
  import cache_pkg::*;
#(
  parameter bit RR_EN    = 1'b1,
  parameter bit WB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ic_rreq,
  input  mem_r_req_bus_t  ic_raddr,
  output logic            ic_rvalid,
  output logic [127:0]    ic_rdata,
  input  logic            dc_rreq,
  input  mem_r_req_bus_t  dc_raddr,
  output logic            dc_rvalid,
  output logic [127:0]    dc_rdata,
  input  logic            dc_wreq,
  input  mem_w_req_bus_t  dc_wbus,
  output logic            dc_wack,
  output logic            mem_ar_valid,
  input  logic            mem_ar_ready,
  output mem_r_req_bus_t  mem_ar,
  input  logic            mem_r_valid,
  input  mem_r_resp_bus_t mem_r,
  output logic            mem_aw_valid,
  input  logic            mem_aw_ready,
  output mem_w_req_bus_t  mem_aw,
  input  logic            mem_b_valid
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_RESP,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    OWN_I,
    OWN_DR,
    OWN_DW
  } owner_t;

  state_t      state;
  owner_t      owner;
  logic        last_grant_d;  // 1 when the most recent read-arbitration grant went to D

  logic        d_read_req;
  logic        pick_d;
  logic        rd_arb;
  logic        grant_valid;
  owner_t      grant;
  logic [31:0] grant_raddr;

  // With WB_FIRST=0 a write-back competes in the read arbitration as a D request.
  always_comb begin
    d_read_req  = WB_FIRST ? dc_rreq : (dc_rreq | dc_wreq);
    pick_d      = 1'b0;
    rd_arb      = 1'b0;
    grant_valid = 1'b0;
    grant       = OWN_I;
    if (WB_FIRST && dc_wreq) begin
      grant_valid = 1'b1;
      grant       = OWN_DW;
    end else if (d_read_req || ic_rreq) begin
      grant_valid = 1'b1;
      rd_arb      = 1'b1;
      if (d_read_req && ic_rreq) begin
        pick_d = RR_EN ? ~last_grant_d : 1'b1;
      end else begin
        pick_d = d_read_req;
      end
      if (!pick_d) begin
        grant = OWN_I;
      end else if (dc_wreq) begin
        grant = OWN_DW;
      end else begin
        grant = OWN_DR;
      end
    end
  end

  assign grant_raddr = (grant == OWN_I) ? ic_raddr.addr : dc_raddr.addr;

  logic unused;
  assign unused = ^{grant_raddr[3:0], dc_wbus.addr[3:0], mem_r.rresp};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= OWN_I;
      last_grant_d <= 1'b0;
      mem_ar_valid <= 1'b0;
      mem_ar       <= '0;
      mem_aw_valid <= 1'b0;
      mem_aw       <= '0;
      ic_rvalid    <= 1'b0;
      dc_rvalid    <= 1'b0;
      dc_wack      <= 1'b0;
      ic_rdata     <= '0;
      dc_rdata     <= '0;
    end else begin
      ic_rvalid <= 1'b0;
      dc_rvalid <= 1'b0;
      dc_wack   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner <= grant;
            if (rd_arb) begin
              last_grant_d <= pick_d;
            end
            if (grant == OWN_DW) begin
              mem_aw.addr  <= {dc_wbus.addr[31:4], 4'h0};
              mem_aw.wdata <= dc_wbus.wdata;
              mem_aw.wmask <= dc_wbus.wmask;
              mem_aw_valid <= 1'b1;
              state        <= WR_ADDR;
            end else begin
              mem_ar.addr  <= {grant_raddr[31:4], 4'h0};
              mem_ar_valid <= 1'b1;
              state        <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (mem_ar_ready) begin
            mem_ar_valid <= 1'b0;
            state        <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (mem_r_valid) begin
            if (owner == OWN_I) begin
              ic_rdata  <= mem_r.rdata;
              ic_rvalid <= 1'b1;
            end else begin
              dc_rdata  <= mem_r.rdata;
              dc_rvalid <= 1'b1;
            end
            state <= RESP;
          end
        end
        WR_ADDR: begin
          if (mem_aw_ready) begin
            mem_aw_valid <= 1'b0;
            state        <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (mem_b_valid) begin
            dc_wack <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/l1_mem_arbiter.md
Name: l1_mem_arbiter

Overview:
- Shares the single 128-bit memory port between the L1 I-cache (line refills) and the L1 D-cache (line refills and write-backs).
- Serializes traffic: exactly one memory transaction outstanding at a time.
- Registers the granted request and steers the memory response back to its owner.
- Uses cache_pkg types mem_r_req_bus_t, mem_r_resp_bus_t, mem_w_req_bus_t and mem_w_resp_bus_t.

Parameters:
RR_EN, 1, 1 = round-robin between I and D reads; 0 = D-cache read always wins.
WB_FIRST, 1, 1 = a pending D-cache write-back beats any read; 0 = write-back joins the read arbitration as a D request.

Ports:
clk  in  1  clock; everything on rising edge
rst  in  1  asynchronous active-high reset
ic_rreq  in  1  I-cache refill request, held until ic_rvalid
ic_raddr  in  mem_r_req_bus_t  I-cache refill address
ic_rvalid  out  1  one-cycle pulse: ic_rdata valid
ic_rdata  out  128  refill line
dc_rreq  in  1  D-cache refill request, held until dc_rvalid
dc_raddr  in  mem_r_req_bus_t  D-cache refill address
dc_rvalid  out  1  one-cycle pulse: dc_rdata valid
dc_rdata  out  128  refill line
dc_wreq  in  1  D-cache write-back request, held until dc_wack
dc_wbus  in  mem_w_req_bus_t  write-back addr/data/wmask
dc_wack  out  1  one-cycle pulse: write-back complete
mem_ar_valid  out  1  read address valid
mem_ar_ready  in  1  memory accepts read address
mem_ar  out  mem_r_req_bus_t  read address
mem_r_valid  in  1  read data valid
mem_r  in  mem_r_resp_bus_t  read data; rresp ignored
mem_aw_valid  out  1  write request valid
mem_aw_ready  in  1  memory accepts write
mem_aw  out  mem_w_req_bus_t  write addr/data/wmask
mem_b_valid  in  1  write response; bresp ignored

Behaviour:
- Reset (async, any time):
  - state=IDLE and last_grant=I (a tie resolves to D first).
  - All outputs 0, including the data and bus fields.
  - Any in-flight memory transaction is abandoned; the memory model must be reset with the arbiter.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, RESP.
- IDLE:
  - Requests are sampled only in IDLE.
  - On the edge where any request is seen, the winner's payload is latched into the memory bus registers and the FSM moves to RD_ADDR or WR_ADDR.
  - Winner selection with WB_FIRST=1: dc_wreq wins over any read.
  - Read selection with RR_EN=1: if only one read request is present, it wins. If both are present, the requester opposite last_grant wins.
  - Read selection with RR_EN=0: D wins.
  - last_grant updates on every read grant.
  - If the D-cache asserts dc_rreq and dc_wreq together, the write is served first (with WB_FIRST=1).
- Address alignment: mem_ar.addr[3:0] and mem_aw.addr[3:0] are forced to 0. dc_wbus data and wmask pass unmodified.
- RD_ADDR: mem_ar_valid=1 with a stable mem_ar. On mem_ar_valid & mem_ar_ready the FSM moves to RD_DATA and mem_ar_valid drops.
- RD_DATA: on mem_r_valid, mem_r.rdata is captured into the owner's rdata register and the FSM moves to RESP.
- WR_ADDR: mem_aw_valid=1. On mem_aw_ready the FSM moves to WR_RESP.
- WR_RESP: on mem_b_valid the FSM moves to RESP.
- RESP:
  - Exactly one of ic_rvalid, dc_rvalid, dc_wack is high for one cycle; the FSM then returns to IDLE.
  - ic_rdata and dc_rdata hold their value until the next refill for that owner.
- Requester rule: deassert the request no later than the cycle after its response pulse. A request still high in IDLE is a new request.
- Latency, request to response pulse:
  - Minimum 3 cycles: request seen at edge 0, ar_valid in cycle 1, ar_ready in cycle 1, r_valid in cycle 2, rvalid pulse in cycle 3.
  - Memory stalls add cycles 1:1.
  - Writes have the same 3-cycle minimum.
- mem_r_valid or mem_b_valid arriving outside RD_DATA or WR_RESP is ignored.
- A request dropped before grant is simply not served. A request dropped after grant is still completed and pulsed.

Test Plan:
- Single I refill, ic_raddr=0x0000_1234, memory ready immediately, rdata=0xA5..A5 -> mem_ar.addr=0x0000_1230; ic_rvalid pulses exactly 3 cycles after request with ic_rdata=0xA5..A5; dc_rvalid stays 0.
- ic_rreq and dc_rreq asserted in the same cycle after reset, RR_EN=1 -> D served first, then I; repeating the tie alternates I, D, I, D; with RR_EN=0, D wins every tie.
- dc_wreq and ic_rreq together, WB_FIRST=1, wmask=0xFFFF -> the mem_aw transaction (addr, data, wmask intact) completes and dc_wack pulses before mem_ar_valid rises for I.
- mem_ar_ready held low 5 cycles and mem_r_valid delayed 4 cycles -> mem_ar stays stable throughout, no second grant occurs, and the response pulse comes exactly 9 cycles later than the minimum.
- rst asserted while in RD_DATA -> all outputs 0 immediately (asynchronous); after release, a stray mem_r_valid produces no pulse; the next request is served normally.
